uart_tx_fifo: RTL

- Parametrised, buffered UART transmitter for the JPEB SoC.
- Replaces the single-byte free-running transmitter: the CPU side pushes words into a FIFO; a serialiser drains them back-to-back.
- Supports configurable data width, parity and stop bits.
- Sits on the CPU clock domain beside the PS/2 and VGA peripherals. Its status feeds memory-mapped reads.

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO of words drained back-to-back by a
// registered-output serialiser (start, data LSB first, optional parity, stop).
module uart_tx_fifo #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   clr_ovf,
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int BCW = $clog2(STOP_BITS * DIV) + 1;
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_LEN  = BCW'(DIV - 1);
  localparam logic [BCW-1:0] STOP_LEN = BCW'(STOP_BITS * DIV - 1);

  // state | meaning
  // IDLE  | line high, waiting for the FIFO to hold a word
  // START | start bit (low)
  // DATA  | data bits, LSB first
  // PAR   | parity bit
  // STOP  | stop bit(s), high
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                state, state_nxt;
  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]  head, shreg;
  logic [IW-1:0]         bit_idx;
  logic [BCW-1:0]        baud_cnt;
  logic                  par_q;
  logic                  push, pop, bit_end, last_bit;
  logic                  tx_nxt, busy_nxt;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_en && !full;
  assign head     = mem[rd_ptr];
  assign bit_end  = (state != IDLE) && (baud_cnt == '0);
  assign last_bit = (bit_idx == IW'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Drops are judged on the registered count, so a pop on the same edge
  // does not rescue a write into a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_bit) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:     if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    tx_nxt   = tx;
    busy_nxt = busy;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          tx_nxt   = 1'b0;
          busy_nxt = 1'b1;
        end
      end
      START: if (bit_end) tx_nxt = shreg[0];
      DATA: begin
        if (bit_end) begin
          if (!last_bit)          tx_nxt = shreg[1];
          else if (PARITY != 0)   tx_nxt = par_q;
          else                    tx_nxt = 1'b1;
        end
      end
      PAR: if (bit_end) tx_nxt = 1'b1;
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop    = 1'b1;
            tx_nxt = 1'b0;
          end else begin
            busy_nxt = 1'b0;
          end
        end
      end
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Parity is captured at pop time because the shift register is consumed
  // while the data bits go out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
    end else begin
      tx   <= tx_nxt;
      busy <= busy_nxt;
      if (pop) begin
        shreg    <= head;
        par_q    <= (^head) ^ (PARITY == 2);
        baud_cnt <= BIT_LEN;
        bit_idx  <= '0;
      end else if (bit_end) begin
        baud_cnt <= (state_nxt == STOP) ? STOP_LEN : BIT_LEN;
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + IW'(1);
        end
      end else if (state != IDLE) begin
        baud_cnt <= baud_cnt - BCW'(1);
      end
    end
  end

endmodule
